// File: rtl/buffer_64_to_512.sv
// Width-up converter: packs 64-bit words into 512-bit words (lane 0 first) and
// queues them in a show-ahead FIFO, with flush of partial words under a lane mask.
module buffer_64_to_512 #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [63:0]              data_in,
  input  logic                     wr_enable,
  input  logic                     flush,
  output logic [511:0]             data_out,
  output logic [7:0]               data_out_mask,
  input  logic                     rd_enable,
  output logic                     full,
  output logic                     full_n,
  output logic                     empty,
  output logic                     partial,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [2:0]   lane_q, lane_d;
  logic [511:0] asm_q, asm_d, word;
  logic [7:0]   mask_q, mask_d, word_mask;
  logic [511:0] mem_data [DEPTH];
  logic [7:0]   mem_mask [DEPTH];
  ptr_t         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t         count_q, count_d;
  logic         wr_acc, flush_acc, push, pop;

  assign full    = (count_q == cnt_t'(DEPTH));
  assign full_n  = (count_q >= cnt_t'(DEPTH - 1));
  assign empty   = (count_q == '0);
  assign partial = (lane_q != 3'd0);
  assign level   = count_q;

  // Full blocks every lane, and a same-cycle pop does not lift the block.
  assign wr_acc    = wr_enable && !full;
  assign flush_acc = flush && !full && (partial || wr_acc);
  assign pop       = rd_enable && !empty;

  always_comb begin
    word      = asm_q;
    word_mask = mask_q;
    if (wr_acc) begin
      word[lane_q*64 +: 64] = data_in;
      word_mask[lane_q]     = 1'b1;
    end
    push = (wr_acc && (lane_q == 3'd7)) || flush_acc;

    lane_d = lane_q;
    asm_d  = asm_q;
    mask_d = mask_q;
    if (push) begin
      lane_d = '0;
      asm_d  = '0;
      mask_d = '0;
    end else if (wr_acc) begin
      lane_d = lane_q + 3'd1;
      asm_d  = word;
      mask_d = word_mask;
    end

    wr_ptr_d = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane_q   <= '0;
      asm_q    <= '0;
      mask_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      lane_q   <= lane_d;
      asm_q    <= asm_d;
      mask_q   <= mask_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr) begin
      mem_data[wr_ptr_q] <= word;
      mem_mask[wr_ptr_q] <= word_mask;
    end
  end

  assign data_out      = empty ? '0 : mem_data[rd_ptr_q];
  assign data_out_mask = empty ? '0 : mem_mask[rd_ptr_q];

endmodule
